// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out stage feeding the sequence detector
module piso_serializer #(
    parameter int   WIDTH     = 8,
    parameter int   MSB_FIRST = 1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             shift_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    logic             state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             ser_out_n, ser_valid_n, ser_last_n;
    logic             at_last, accept;

    // Handshake: ready in IDLE, or on the edge that consumes the final bit so frames chain without a gap.
    always_comb begin
        at_last    = (state == ST_SHIFT) && (cnt == LAST_CNT);
        load_ready = (state == ST_IDLE) || (at_last && shift_en);
        accept     = load_valid && load_ready;
    end

    // Next-state and next-output computation; ser_out is registered from the next head bit.
    always_comb begin
        state_n = state;
        sreg_n  = sreg;
        cnt_n   = cnt;
        if (accept) begin
            state_n = ST_SHIFT;
            sreg_n  = data_in;
            cnt_n   = '0;
        end else if (state == ST_SHIFT && shift_en) begin
            if (cnt == LAST_CNT) begin
                state_n = ST_IDLE;
                sreg_n  = '0;
                cnt_n   = '0;
            end else begin
                sreg_n = (MSB_FIRST != 0) ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
                cnt_n  = cnt + 1'b1;
            end
        end

        if (state_n == ST_SHIFT) begin
            ser_out_n   = (MSB_FIRST != 0) ? sreg_n[WIDTH-1] : sreg_n[0];
            ser_valid_n = 1'b1;
            ser_last_n  = (cnt_n == LAST_CNT);
        end else begin
            ser_out_n   = IDLE_BIT;
            ser_valid_n = 1'b0;
            ser_last_n  = 1'b0;
        end
    end

    // State and output flops; reset abandons any frame in flight immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            sreg      <= '0;
            cnt       <= '0;
            ser_out   <= IDLE_BIT;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
        end else begin
            state     <= state_n;
            sreg      <= sreg_n;
            cnt       <= cnt_n;
            ser_out   <= ser_out_n;
            ser_valid <= ser_valid_n;
            ser_last  <= ser_last_n;
        end
    end

    assign busy = (state == ST_SHIFT);

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - randomized and directed checks of piso_serializer against a bit-index model
module tb_piso_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         lv  = 1'b0;
    logic         se  = 1'b0;
    logic [W-1:0] d   = '0;

    logic lr_a, so_a, sv_a, sl_a, bz_a;
    logic lr_b, so_b, sv_b, sl_b, bz_b;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1), .IDLE_BIT(1'b0)) dut_msb (
        .clk(clk), .rst(rst), .load_valid(lv), .load_ready(lr_a), .data_in(d),
        .shift_en(se), .ser_out(so_a), .ser_valid(sv_a), .ser_last(sl_a), .busy(bz_a)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(0), .IDLE_BIT(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .load_valid(lv), .load_ready(lr_b), .data_in(d),
        .shift_en(se), .ser_out(so_b), .ser_valid(sv_b), .ser_last(sl_b), .busy(bz_b)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the active frame word and the index of the bit currently on the line.
    bit           m_act   = 1'b0;
    logic [W-1:0] m_frame = '0;
    int           m_pos   = 0;

    function automatic logic m_ready();
        return !m_act || (m_pos == W - 1 && se);
    endfunction

    function automatic logic m_bit(input bit msb);
        if (!m_act) return 1'b0;
        return msb ? m_frame[W-1-m_pos] : m_frame[m_pos];
    endfunction

    // Model advance on each edge using the inputs presented before it.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act   <= 1'b0;
            m_frame <= '0;
            m_pos   <= 0;
        end else if (lv && m_ready()) begin
            m_act   <= 1'b1;
            m_frame <= d;
            m_pos   <= 0;
        end else if (m_act && se) begin
            if (m_pos == W - 1) m_act <= 1'b0;
            else                m_pos <= m_pos + 1;
        end
    end

    // Compare both instances against the model every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            chk1("msb ser_out",    so_a, m_bit(1'b1));
            chk1("lsb ser_out",    so_b, m_bit(1'b0));
            chk1("msb ser_valid",  sv_a, m_act);
            chk1("lsb ser_valid",  sv_b, m_act);
            chk1("msb ser_last",   sl_a, m_act && m_pos == W - 1);
            chk1("lsb ser_last",   sl_b, m_act && m_pos == W - 1);
            chk1("msb busy",       bz_a, m_act);
            chk1("lsb busy",       bz_b, m_act);
            chk1("msb load_ready", lr_a, m_ready());
            chk1("lsb load_ready", lr_b, m_ready());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  sa, sb, va, la;
    logic [15:0] s16;
    logic [10:0] s11, l11;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        #1;
        chk1("reset ser_out", so_a, 1'b0);
        chk1("reset ser_valid", sv_a, 1'b0);
        chk1("reset ser_last", sl_a, 1'b0);
        chk1("reset busy", bz_a, 1'b0);
        chk1("reset load_ready", lr_a, 1'b1);

        // Basic frame, both bit orders
        se = 1'b1; lv = 1'b1; d = 8'hB4;
        step();
        lv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sa[7-i] = so_a; sb[7-i] = so_b; va[7-i] = sv_a; la[7-i] = sl_a;
            step();
        end
        chk32("basic msb stream", 32'(sa), 32'h0000_00B4);
        chk32("basic lsb stream", 32'(sb), 32'h0000_002D);
        chk32("basic valid mask", 32'(va), 32'h0000_00FF);
        chk32("basic last mask", 32'(la), 32'h0000_0001);
        chk1("basic idle ser_out", so_a, 1'b0);
        chk1("basic idle busy", bz_a, 1'b0);

        // Back-to-back frames with no gap bit
        lv = 1'b1; d = 8'hFF;
        step();
        d = 8'h00;
        for (int i = 0; i < 16; i++) begin
            if (i == 3) chk1("b2b ready mid", lr_a, 1'b0);
            if (i == 7) chk1("b2b ready last", lr_a, 1'b1);
            if (i == 8) lv = 1'b0;
            s16[15-i] = so_a;
            step();
        end
        chk32("b2b stream", 32'(s16), 32'h0000_FF00);

        // Stall for three edges after the third bit
        lv = 1'b1; d = 8'hB4;
        step();
        lv = 1'b0;
        for (int i = 0; i < 11; i++) begin
            s11[10-i] = so_a; l11[10-i] = sl_a;
            se = (i >= 3 && i <= 5) ? 1'b0 : 1'b1;
            step();
        end
        se = 1'b1;
        chk32("stall stream", 32'(s11), 32'h0000_05F4);
        chk32("stall last mask", 32'(l11), 32'h0000_0001);

        // Load attempted while busy is held off until the last-bit edge
        lv = 1'b1; d = 8'hB4;
        step();
        lv = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 3) begin
                lv = 1'b1; d = 8'h0F;
                #1;
                chk1("busy load ready", lr_a, 1'b0);
            end
            if (i == 7) chk1("busy load ready last", lr_a, 1'b1);
            if (i == 8) lv = 1'b0;
            s16[15-i] = so_a;
            step();
        end
        chk32("busy load stream", 32'(s16), 32'h0000_B40F);

        // Asynchronous reset during bit 5
        lv = 1'b1; d = 8'hB4;
        step();
        lv = 1'b0;
        repeat (5) step();
        chk1("pre-reset bit5", so_a, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk1("async rst ser_out", so_a, 1'b0);
        chk1("async rst ser_valid", sv_a, 1'b0);
        chk1("async rst busy", bz_a, 1'b0);
        chk1("async rst lsb busy", bz_b, 1'b0);
        step();
        rst = 1'b0;
        #1;
        chk1("post rst ready", lr_a, 1'b1);
        lv = 1'b1; d = 8'hB4;
        step();
        lv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sa[7-i] = so_a;
            step();
        end
        chk32("post rst stream", 32'(sa), 32'h0000_00B4);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if (!lv || lr_a) begin
                lv = ($urandom_range(0, 2) != 0);
                d  = 8'($urandom);
            end
            se = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
